// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register bank.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic RW_WRITE = 1'b1;

  // Total frame length: R/W bit + address field + data field.
  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser plus history flop; reports settled level and single-cycle edges.
// The history flop always follows the settled stage, so reset never fabricates an edge
// from a pin that is held steady across it.
module spi_sync_edge (
  input  logic clk,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q;
  logic       hist_q;

  // Synchroniser chain and history stage.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[0], d_i};
    hist_q <= sync_q[1];
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~hist_q;
  assign fall_o  = ~sync_q[1] & hist_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral driving a bank of configuration registers.
// Optional register readback on CIPO is enabled with the SPI_READBACK_EN macro.
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 7,
  parameter int unsigned          DATA_W    = 8,
  parameter int unsigned          NUM_REGS  = 5,
  parameter logic [DATA_W-1:0]    RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         nCS,
  input  logic                         SCLK,
  input  logic                         COPI,
  output logic                         CIPO,
  output logic [NUM_REGS*DATA_W-1:0]   regs_out,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         addr_err,
  output logic                         frame_err
);

  localparam int unsigned      FRAME_W  = frame_w(ADDR_W, DATA_W);
  localparam int unsigned      CNT_W    = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [ADDR_W:0]  NREGS_A  = (ADDR_W + 1)'(NUM_REGS);

  logic ncs_lvl, ncs_rise, ncs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic [1:0] copi_q;

  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [FRAME_W-1:0]           shreg_q, shreg_d;
  logic [NUM_REGS*DATA_W-1:0]   regs_q, regs_d;
  logic                         wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]            wr_addr_q, wr_addr_d;
  logic                         addr_err_q, addr_err_d;
  logic                         frame_err_q, frame_err_d;

  logic                         fr_rw;
  logic [ADDR_W-1:0]            fr_addr;
  logic [DATA_W-1:0]            fr_data;

  spi_sync_edge u_sync_ncs (
    .clk     (clk),
    .d_i     (nCS),
    .level_o (ncs_lvl),
    .rise_o  (ncs_rise),
    .fall_o  (ncs_fall)
  );

  spi_sync_edge u_sync_sclk (
    .clk     (clk),
    .d_i     (SCLK),
    .level_o (sclk_lvl),
    .rise_o  (sclk_rise),
    .fall_o  (sclk_fall)
  );

  // COPI runs through the same two-flop depth so it lines up with the detected SCLK edge.
  always_ff @(posedge clk) begin
    copi_q <= {copi_q[0], COPI};
  end

  assign fr_rw   = shreg_q[FRAME_W-1];
  assign fr_addr = shreg_q[DATA_W +: ADDR_W];
  assign fr_data = shreg_q[DATA_W-1:0];

  // Frame state register and bank storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      regs_q      <= {NUM_REGS{RESET_VAL}};
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      addr_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      regs_q      <= regs_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      addr_err_q  <= addr_err_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Frame sequencing: collect bits, commit once, ignore trailing clocks until deselect.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    regs_d      = regs_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    addr_err_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ncs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SHIFT: begin
        // A final bit arriving with deselect is taken first, so the frame still completes.
        if (sclk_rise && (cnt_q != CNT_FULL)) begin
          shreg_d = {shreg_q[FRAME_W-2:0], copi_q[1]};
          cnt_d   = cnt_q + 1'b1;
        end
        if (cnt_d == CNT_FULL) begin
          state_d = COMMIT;
        end else if (ncs_rise) begin
          frame_err_d = 1'b1;
          state_d     = IDLE;
        end
      end
      COMMIT: begin
        if (fr_rw == RW_WRITE) begin
          if ({1'b0, fr_addr} < NREGS_A) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (fr_addr == ADDR_W'(i)) regs_d[i*DATA_W +: DATA_W] = fr_data;
            end
            wr_strobe_d = 1'b1;
            wr_addr_d   = fr_addr;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        state_d = DONE;
      end
      DONE: begin
        if (ncs_lvl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign regs_out  = regs_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign addr_err  = addr_err_q;
  assign frame_err = frame_err_q;

`ifdef SPI_READBACK_EN
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(1 + ADDR_W);

  logic [DATA_W-1:0] rd_sh_q, rd_sh_d;
  logic              rd_act_q, rd_act_d;
  logic              cipo_q, cipo_d;
  logic [DATA_W-1:0] rd_word;

  // Readback shifter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sh_q  <= '0;
      rd_act_q <= 1'b0;
      cipo_q   <= 1'b0;
    end else begin
      rd_sh_q  <= rd_sh_d;
      rd_act_q <= rd_act_d;
      cipo_q   <= cipo_d;
    end
  end

  // Load the addressed register after the last address bit; shift one bit out per SCLK fall.
  always_comb begin
    rd_sh_d  = rd_sh_q;
    rd_act_d = rd_act_q;
    cipo_d   = cipo_q;
    rd_word  = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (shreg_d[ADDR_W-1:0] == ADDR_W'(i)) rd_word = regs_q[i*DATA_W +: DATA_W];
    end
    if ((state_q == SHIFT) && sclk_rise && (cnt_d == CNT_ADDR) && (shreg_d[ADDR_W] != RW_WRITE)) begin
      rd_sh_d  = rd_word;
      rd_act_d = 1'b1;
    end
    if (sclk_fall && rd_act_q) begin
      if ((state_q == SHIFT) && (cnt_q != CNT_FULL)) begin
        cipo_d  = rd_sh_q[DATA_W-1];
        rd_sh_d = {rd_sh_q[DATA_W-2:0], 1'b0};
      end else begin
        cipo_d   = 1'b0;
        rd_act_d = 1'b0;
      end
    end
    if (ncs_lvl || (state_q == IDLE)) begin
      cipo_d   = 1'b0;
      rd_act_d = 1'b0;
    end
  end

  assign CIPO = cipo_q;
`else
  assign CIPO = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Scoreboard bench for spi_reg_bank: directed cases plus randomized frames against a register-array model.
module tb_spi_reg_bank;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 5;
  localparam int FRAME_W  = 1 + ADDR_W + DATA_W;
  localparam int BANK_W   = NUM_REGS * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              nCS;
  logic              SCLK;
  logic              COPI;
  logic              CIPO;
  logic [BANK_W-1:0] regs_out;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic              addr_err;
  logic              frame_err;

  typedef struct {
    logic [2:0]        flags;  // {wr_strobe, addr_err, frame_err}
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  model [NUM_REGS];
  int          checks = 0;
  int          passes = 0;

  spi_reg_bank #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .RESET_VAL('0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .nCS       (nCS),
    .SCLK      (SCLK),
    .COPI      (COPI),
    .CIPO      (CIPO),
    .regs_out  (regs_out),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .addr_err  (addr_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  function automatic logic [BANK_W-1:0] model_bank();
    logic [BANK_W-1:0] b;
    for (int i = 0; i < NUM_REGS; i++) b[i*DATA_W +: DATA_W] = model[i];
    return b;
  endfunction

  function automatic logic [7:0] model_read(input logic [ADDR_W-1:0] a);
    if (int'(a) < NUM_REGS) return model[int'(a)];
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference outcome of one frame from its content and number of clocks received.
  task automatic model_frame(input logic [15:0] f, input int nbits);
    exp_t e;
    logic [ADDR_W-1:0] a;
    a = f[14:8];
    e.addr = a;
    if (nbits < FRAME_W) begin
      e.flags = 3'b001;
      e.bank  = model_bank();
      exp_q.push_back(e);
    end else if (f[15]) begin
      if (int'(a) < NUM_REGS) begin
        model[int'(a)] = f[7:0];
        e.flags = 3'b100;
      end else begin
        e.flags = 3'b010;
      end
      e.bank = model_bank();
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      clks(1);
      n++;
    end
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    check("regs_after_frame", 64'(regs_out), 64'(model_bank()));
  endtask

  // One SCLK cycle (10 clk): data set on low phase, CIPO sampled as SCLK rises.
  task automatic sclk_bit(input logic b, input int idx, input logic is_read, input logic [7:0] rd, input bit with_cs_rise);
    logic exp_cipo;
    COPI = b;
    clks(5);
    exp_cipo = 1'b0;
`ifdef SPI_READBACK_EN
    if (is_read && idx >= 8 && idx < FRAME_W) exp_cipo = rd[FRAME_W - 1 - idx];
`endif
    check($sformatf("cipo_bit%0d", idx), 64'(CIPO), 64'(exp_cipo));
    SCLK = 1'b1;
    if (with_cs_rise) nCS = 1'b1;
    clks(5);
    SCLK = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] f, input int nbits, input bit same_end);
    logic [7:0] rd;
    logic       is_read;
    is_read = ~f[15];
    rd      = model_read(f[14:8]);
    model_frame(f, nbits);
    nCS = 1'b0;
    clks(6);
    for (int i = 0; i < nbits; i++) begin
      sclk_bit((i < FRAME_W) ? f[FRAME_W - 1 - i] : 1'($urandom), i, is_read, rd,
               same_end && (i == nbits - 1));
    end
    if (!same_end) begin
      clks(5);
      nCS = 1'b1;
    end
    COPI = 1'b0;
    clks(8);
    wait_drain();
  endtask

  // Monitor: every pulse must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (wr_strobe || addr_err || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 64'({wr_strobe, addr_err, frame_err}), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("pulse_flags", 64'({wr_strobe, addr_err, frame_err}), 64'(e.flags));
        if (e.flags[2]) check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("regs_at_pulse", 64'(regs_out), 64'(e.bank));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] f;
    int          r;
    int          nb;
    bit          se;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    rst = 1'b1; nCS = 1'b1; SCLK = 1'b0; COPI = 1'b0;
    clks(5);
    check("reset_regs", 64'(regs_out), 64'd0);
    check("reset_pulses", 64'({wr_strobe, addr_err, frame_err}), 64'd0);
    check("reset_wr_addr", 64'(wr_addr), 64'd0);
    check("reset_cipo", 64'(CIPO), 64'd0);
    rst = 1'b0;
    clks(5);

    send_frame(16'h83A5, 16, 1'b0);   // write reg3
    send_frame(16'h8F11, 16, 1'b0);   // out-of-range address
    send_frame(16'h8255, 10, 1'b0);   // truncated frame
    send_frame(16'h8255, 16, 1'b0);   // recovers
    send_frame(16'h8177, 20, 1'b0);   // trailing clocks ignored
    send_frame(16'h8433, 16, 1'b1);   // last bit with deselect
    send_frame(16'h0300, 16, 1'b0);   // readback reg3
    send_frame(16'h0700, 16, 1'b0);   // readback out of range

    // Reset mid-frame: frame dropped with no pulse, later clocks ignored.
    nCS = 1'b0;
    clks(6);
    for (int i = 0; i < 6; i++) sclk_bit(1'b1, i, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    clks(4);
    rst = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    check("midframe_reset_regs", 64'(regs_out), 64'd0);
    for (int i = 0; i < 10; i++) begin
      COPI = 1'b1; clks(5); SCLK = 1'b1; clks(5); SCLK = 1'b0;
    end
    clks(5);
    nCS = 1'b1;
    clks(8);
    wait_drain();
    send_frame(16'h8099, 16, 1'b0);

    // Randomized frames.
    for (int k = 0; k < 30; k++) begin
      f  = {1'($urandom), 7'($urandom_range(0, 7)), 8'($urandom)};
      r  = $urandom_range(0, 3);
      se = 1'b0;
      case (r)
        0:       nb = FRAME_W;
        1:       nb = FRAME_W + $urandom_range(1, 5);
        2:       nb = $urandom_range(1, FRAME_W - 1);
        default: begin nb = FRAME_W; se = 1'b1; end
      endcase
      send_frame(f, nb, se);
    end

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
